dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store path (port C) and a debug/loader port (port D).
- Port D preloads and dumps data memory and inspects it at run time, replacing the bench backdoor accesses.
- Round-robin arbitration, plus a bounded lock that lets D perform atomic bursts.
- Sits between the core/debug logic and data_mem.

---
 rtl/dmem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : round-robin core/debug share of the data-memory port,
//                     with a bounded debug lock for atomic bursts.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_core_req,
  input  logic                i_core_we,
  input  logic [ADDR_W-1:0]   i_core_addr,
  input  logic [DATA_W-1:0]   i_core_wdata,
  input  logic [DATA_W/8-1:0] i_core_wstrb,
  output logic                o_core_gnt,
  output logic                o_core_rvalid,
  output logic [DATA_W-1:0]   o_core_rdata,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [ADDR_W-1:0]   i_dbg_addr,
  input  logic [DATA_W-1:0]   i_dbg_wdata,
  input  logic [DATA_W/8-1:0] i_dbg_wstrb,
  input  logic                i_dbg_lock,
  output logic                o_dbg_gnt,
  output logic                o_dbg_rvalid,
  output logic [DATA_W-1:0]   o_dbg_rdata,
  output logic                o_core_stall,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [0:0] {S_RR = 1'b0, S_LOCK = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last, w_last_nxt;   // 1 = debug port won last
  logic [CNT_W-1:0] r_lock_cnt, w_cnt_nxt;
  logic             r_rd_pend;
  logic             r_rd_dbg;
  logic             w_core_gnt, w_dbg_gnt;

  // Grants are forced low while reset is held so every output reads as zero.
  always_comb begin
    w_core_gnt  = 1'b0;
    w_dbg_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_lock_cnt;
    if (!rst) begin
      case (r_state)
        S_RR: begin
          w_core_gnt = i_core_req & (~i_dbg_req | r_last);
          w_dbg_gnt  = i_dbg_req & (~i_core_req | ~r_last);
          if (w_core_gnt) begin
            w_last_nxt = 1'b0;
          end else if (w_dbg_gnt) begin
            w_last_nxt = 1'b1;
            if (i_dbg_lock) begin
              w_state_nxt = S_LOCK;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        S_LOCK: begin
          w_dbg_gnt = i_dbg_req;
          if (!i_dbg_lock || (r_lock_cnt == c_CNT_LAST)) begin
            w_state_nxt = S_RR;
            w_last_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_lock_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = S_RR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RR;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_dbg   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_rd_pend  <= (w_core_gnt & ~i_core_we) | (w_dbg_gnt & ~i_dbg_we);
      r_rd_dbg   <= w_dbg_gnt;
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    if (w_dbg_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
      o_mem_wstrb = i_dbg_wstrb;
    end else if (w_core_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
      o_mem_wstrb = i_core_wstrb;
    end
  end

  assign o_core_gnt    = w_core_gnt;
  assign o_dbg_gnt     = w_dbg_gnt;
  assign o_core_stall  = ~rst & i_core_req & ~w_core_gnt;
  assign o_core_rvalid = r_rd_pend & ~r_rd_dbg;
  assign o_dbg_rvalid  = r_rd_pend & r_rd_dbg;
  assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
  assign o_dbg_rdata   = o_dbg_rvalid ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter : directed self-checking bench for dmem_port_arbiter.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int LOCK_MAX = 16;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  logic core_req, core_we, core_gnt, core_rvalid, core_stall;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic [STRB_W-1:0] core_wstrb;
  logic dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [STRB_W-1:0] dbg_wstrb;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [STRB_W-1:0] mem_wstrb;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_wstrb(core_wstrb),
    .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .i_dbg_wstrb(dbg_wstrb), .i_dbg_lock(dbg_lock),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_core_stall(core_stall),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
  );

  // Memory model with one-cycle read latency and byte-strobed writes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < STRB_W; b++)
          if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    mem[12'h010] = 64'hAAAA_AAAA_AAAA_AAAA;
    mem[12'h011] = 64'hBBBB_BBBB_BBBB_BBBB;
    mem_rdata = '0;
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0; dbg_lock = 0;
    repeat (2) step();

    // Requests present while reset held: everything stays zero
    core_req = 1; core_we = 1; core_addr = 12'h001; core_wstrb = '0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h002; dbg_wstrb = '0;
    #1;
    chk("rst_core_gnt", 64'(core_gnt), 64'd0);
    chk("rst_dbg_gnt", 64'(dbg_gnt), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_stall", 64'(core_stall), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rvalid", 64'({core_rvalid, dbg_rvalid}), 64'd0);

    // Tie: C, D, C, D
    step(); rst = 1'b0; #1;
    chk("rr0_core_gnt", 64'(core_gnt), 64'd1);
    chk("rr0_dbg_gnt", 64'(dbg_gnt), 64'd0);
    chk("rr0_stall", 64'(core_stall), 64'd0);
    chk("rr0_addr", 64'(mem_addr), 64'h001);
    step(); #1;
    chk("rr1_dbg_gnt", 64'(dbg_gnt), 64'd1);
    chk("rr1_stall", 64'(core_stall), 64'd1);
    chk("rr1_addr", 64'(mem_addr), 64'h002);
    step(); #1;
    chk("rr2_core_gnt", 64'(core_gnt), 64'd1);
    chk("rr2_stall", 64'(core_stall), 64'd0);
    step(); #1;
    chk("rr3_dbg_gnt", 64'(dbg_gnt), 64'd1);
    chk("rr3_core_gnt", 64'(core_gnt), 64'd0);

    // Core back-to-back reads
    step(); dbg_req = 0; core_we = 0; core_addr = 12'h010; #1;
    chk("rd0_gnt", 64'(core_gnt), 64'd1);
    chk("rd0_mem_we", 64'(mem_we), 64'd0);
    step(); core_addr = 12'h011; #1;
    chk("rd1_gnt", 64'(core_gnt), 64'd1);
    chk("rd1_rvalid", 64'(core_rvalid), 64'd1);
    chk("rd1_rdata", core_rdata, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rd1_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
    chk("rd1_dbg_rdata", dbg_rdata, 64'd0);
    step(); core_req = 0; #1;
    chk("rd2_rvalid", 64'(core_rvalid), 64'd1);
    chk("rd2_rdata", core_rdata, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("rd2_mem_en", 64'(mem_en), 64'd0);
    step(); #1;
    chk("rd3_rvalid", 64'(core_rvalid), 64'd0);

    // Debug strobed write
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h020; dbg_wdata = 64'h0123_4567_89AB_CDEF; dbg_wstrb = 8'h0F;
    #1;
    chk("wr_gnt", 64'(dbg_gnt), 64'd1);
    chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_wstrb", 64'(mem_wstrb), 64'h0F);
    chk("wr_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    step(); dbg_req = 0; #1;
    chk("wr_no_rvalid", 64'({core_rvalid, dbg_rvalid}), 64'd0);
    chk("wr_mem_data", mem[12'h020], 64'h0000_0000_89AB_CDEF);

    // Core access so debug wins the next tie
    core_req = 1; core_we = 1; core_addr = 12'h030; core_wstrb = '0; #1;
    chk("pre_lock_core", 64'(core_gnt), 64'd1);

    // Full-length lock: 16 debug grants, core on the 17th
    step(); dbg_req = 1; dbg_lock = 1; dbg_addr = 12'h030; dbg_wstrb = '0;
    for (int i = 0; i < LOCK_MAX; i++) begin
      #1;
      chk($sformatf("lock_dbg_gnt_%0d", i), 64'(dbg_gnt), 64'd1);
      chk($sformatf("lock_core_gnt_%0d", i), 64'(core_gnt), 64'd0);
      chk($sformatf("lock_stall_%0d", i), 64'(core_stall), 64'd1);
      step();
    end
    #1;
    chk("lock_end_core_gnt", 64'(core_gnt), 64'd1);
    chk("lock_end_dbg_gnt", 64'(dbg_gnt), 64'd0);

    // Short lock dropped after 3 cycles while core waits
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("short_dbg_gnt_%0d", i), 64'(dbg_gnt), 64'd1);
      step();
    end
    dbg_req = 0; dbg_lock = 0; #1;
    chk("short_drop_core_gnt", 64'(core_gnt), 64'd0);
    step(); #1;
    chk("short_after_core_gnt", 64'(core_gnt), 64'd1);
    chk("short_lock_cnt", 64'(dut.r_lock_cnt), 64'd0);

    // Reset during lock with a debug read in flight
    step(); dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 12'h010; #1;
    chk("rl_dbg_gnt0", 64'(dbg_gnt), 64'd1);
    step(); #1;
    chk("rl_dbg_gnt1", 64'(dbg_gnt), 64'd1);
    step(); rst = 1'b1; #1;
    chk("rl_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
    chk("rl_dbg_rdata", dbg_rdata, 64'd0);
    chk("rl_gnts", 64'({core_gnt, dbg_gnt}), 64'd0);
    chk("rl_mem_en", 64'(mem_en), 64'd0);
    chk("rl_stall", 64'(core_stall), 64'd0);
    step(); rst = 1'b0; dbg_lock = 0; core_we = 0; core_addr = 12'h010; dbg_addr = 12'h011; #1;
    chk("rl_post_core_gnt", 64'(core_gnt), 64'd1);
    chk("rl_post_dbg_gnt", 64'(dbg_gnt), 64'd0);
    chk("rl_post_dbg_rvalid", 64'(dbg_rvalid), 64'd0);

    // Back-to-back reads routed to their own owners
    step(); core_req = 0; #1;
    chk("rt_dbg_gnt", 64'(dbg_gnt), 64'd1);
    chk("rt_core_rdata", core_rdata, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("rt_dbg_rdata0", dbg_rdata, 64'd0);
    step(); dbg_req = 0; #1;
    chk("rt_dbg_rvalid", 64'(dbg_rvalid), 64'd1);
    chk("rt_dbg_rdata1", dbg_rdata, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("rt_core_rvalid", 64'(core_rvalid), 64'd0);
    chk("rt_core_rdata1", core_rdata, 64'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
